calc_entry_fsm: RTL
===================

CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 Parameter: SHOW_CYCLES, default 50_000_000, number of clk cycles the result phase is held (1 s at 50 MHz).
REQ-002 Parameter: CNT_W, default 26, width of the show-phase counter; SHOW_CYCLES SHALL fit in CNT_W bits.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sw  input  10  slide switches; sw[7:0] is the operand value, sw[1:0] is the op select, and sw[9:8] are ignored.
REQ-006 Port: pb_enter  input  1  debounced, active-high "enter" button level.
REQ-007 Port: pb_clear  input  1  debounced, active-high "clear" button level.
REQ-008 Port: en  output  4  one-hot phase: 0001 A entry, 0010 B entry, 0100 op entry, 1000 show result.
REQ-009 Port: operand_a  output  8  captured operand A.
REQ-010 Port: operand_b  output  8  captured operand B.
REQ-011 Port: op  output  2  captured operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-012 Port: calc_start  output  1  one-cycle pulse on entry to the show phase.
REQ-013 Port: error  output  1  high during the show phase when the captured op is divide and operand_b is 0.

Function
REQ-014 Each button SHALL be edge-detected: press = level & ~prev, with prev registered every cycle.
REQ-015 The FSM SHALL have states A_ENTRY, B_ENTRY, OP_ENTRY and SHOW, and en SHALL be the one-hot encoding of the current state.
REQ-016 In A_ENTRY, a press of pb_enter SHALL load operand_a <= sw[7:0] and move the FSM to B_ENTRY.
REQ-017 In B_ENTRY, a press of pb_enter SHALL load operand_b <= sw[7:0] and move the FSM to OP_ENTRY.
REQ-018 In OP_ENTRY, a press of pb_enter SHALL load op <= sw[1:0], move the FSM to SHOW, assert calc_start for exactly that transition cycle +1 (the first SHOW cycle), and clear the counter to 0.
REQ-019 On entry to SHOW, error SHALL be set to 1 when sw[1:0]==11 and operand_b==0, and to 0 otherwise; it is held for the whole SHOW phase.
REQ-020 In SHOW, the counter SHALL increment each cycle; when it reaches SHOW_CYCLES-1, the FSM SHALL go to A_ENTRY on the next edge.
REQ-021 A press of pb_enter in SHOW SHALL return the FSM to A_ENTRY immediately, on the next edge, regardless of the counter value.
REQ-022 Operands and op SHALL stay stable outside their own capture edge; returning to A_ENTRY does not clear them.
REQ-023 A press of pb_clear in any state SHALL move the FSM to A_ENTRY and zero operand_a, operand_b, op, error and the counter.
REQ-024 When pb_clear and pb_enter presses occur in the same cycle, clear SHALL win and no capture SHALL occur.
REQ-025 A held button SHALL produce exactly one press; releasing it SHALL produce nothing.
REQ-026 When the FSM leaves SHOW, error SHALL drop to 0.
REQ-027 calc_start SHALL never be high in two consecutive cycles.
REQ-028 Latency from a button press to the updated outputs SHALL be 2 clk edges: the edge register, then the state/data register.

Reset
REQ-029 While reset is high, the module SHALL hold: state=A_ENTRY (en=0001), operand_a=0, operand_b=0, op=00, calc_start=0, error=0, counter=0.
REQ-030 While reset is high, both prev registers SHALL be loaded to 1, so a button held through reset release yields no press.
REQ-031 Reset SHALL take priority over every button event, including mid-operation in SHOW.

Structure
REQ-032 Shared package calc_pkg SHALL hold the state encodings (one-hot 4-bit) and the op codes OP_ADD, OP_SUB, OP_MUL, OP_DIV.
REQ-033 One sub-module, calc_edge_detect (1-bit, clk/reset, level in, press out, prev reset to 1), SHALL be instantiated twice: once for enter and once for clear.

Verification
REQ-034 Reset, then enter presses with sw=0x12, 0x05, 0x02 -> operand_a=0x12, operand_b=0x05, op=10, en=1000, calc_start a single pulse, error=0.
REQ-035 Same sequence with B=0x00 and op sw=0x03 -> error=1 throughout SHOW, and 0 after the return to A_ENTRY.
REQ-036 SHOW_CYCLES=8, no press -> en=1000 for exactly 8 cycles, then 0001.
REQ-037 In B_ENTRY, pb_enter and pb_clear rise in the same cycle -> en=0001, all operands 0, operand_b not loaded.
REQ-038 pb_enter held high across reset release and for 20 cycles -> no state change; release and press again -> exactly one advance.
REQ-039 Reset asserted for 1 cycle mid-SHOW (counter=3) -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry controller: one-hot phase
// encodings and the operation codes captured from the switches.
package calc_pkg;

  typedef enum logic [3:0] {
    ST_A_ENTRY  = 4'b0001,
    ST_B_ENTRY  = 4'b0010,
    ST_OP_ENTRY = 4'b0100,
    ST_SHOW     = 4'b1000
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/calc_edge_detect.sv
// Rising-edge detector for a debounced button level. The press output is
// registered, so a press is visible one edge after the level rises. prev
// resets to 1 so a button held through reset release never counts as a press.
module calc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev;

  // Track the previous level and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b1;
      press <= 1'b0;
    end else begin
      prev  <= level;
      press <= level & ~prev;
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator entry sequencer: captures operand A, operand B and the op from
// the switches on successive enter presses, then holds a result phase for
// SHOW_CYCLES clocks (or until another enter press).
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_A_ENTRY  | waiting for enter to capture operand A
//   ST_B_ENTRY  | waiting for enter to capture operand B
//   ST_OP_ENTRY | waiting for enter to capture op, start calc
//   ST_SHOW     | result shown; timeout or enter returns to A
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic       pb_enter,
  input  logic       pb_clear,
  output logic [3:0] en,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic [1:0] op,
  output logic       calc_start,
  output logic       error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       a_d, b_d;
  logic [1:0]       op_d;
  logic             err_d, start_d;
  logic             enter_press, clear_press;

  // sw[9:8] carry no meaning for this block.
  logic unused_sw;
  assign unused_sw = ^sw[9:8];

  calc_edge_detect u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .level (pb_enter),
    .press (enter_press)
  );

  calc_edge_detect u_clear_edge (
    .clk   (clk),
    .reset (reset),
    .level (pb_clear),
    .press (clear_press)
  );

  assign en = state_q;

  // State and datapath registers; reset beats every button event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_A_ENTRY;
      cnt_q      <= '0;
      operand_a  <= 8'h00;
      operand_b  <= 8'h00;
      op         <= OP_ADD;
      error      <= 1'b0;
      calc_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      operand_a  <= a_d;
      operand_b  <= b_d;
      op         <= op_d;
      error      <= err_d;
      calc_start <= start_d;
    end
  end

  // Next-state and capture logic; clear overrides any simultaneous enter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = operand_a;
    b_d     = operand_b;
    op_d    = op;
    err_d   = error;
    start_d = 1'b0;

    if (clear_press) begin
      state_d = ST_A_ENTRY;
      cnt_d   = '0;
      a_d     = 8'h00;
      b_d     = 8'h00;
      op_d    = OP_ADD;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_A_ENTRY: begin
          if (enter_press) begin
            a_d     = sw[7:0];
            state_d = ST_B_ENTRY;
          end
        end
        ST_B_ENTRY: begin
          if (enter_press) begin
            b_d     = sw[7:0];
            state_d = ST_OP_ENTRY;
          end
        end
        ST_OP_ENTRY: begin
          if (enter_press) begin
            op_d    = sw[1:0];
            err_d   = (sw[1:0] == OP_DIV) && (operand_b == 8'h00);
            cnt_d   = '0;
            start_d = 1'b1;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (enter_press || (cnt_q == CNT_LAST)) begin
            err_d   = 1'b0;
            state_d = ST_A_ENTRY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_A_ENTRY;
        end
      endcase
    end
  end

endmodule
